// File: rtl/wbsplitter.sv
// Pipelined Wishbone B4 1-to-2 splitter. One master is routed to slave A or slave B by
// address decode (A wins on overlap). Outstanding requests are counted so responses come
// back in order from the slave that owns the burst; an unmapped accept returns a one-cycle
// error one cycle later.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cyc/i_stb/i_we/     master request (address, write data, byte selects)
//   i_adr/i_dat/i_sel
//   o_ack/o_stall/o_err/  master response and read data
//   o_data
//   o_a_* / o_b_*         slave request lines (we/adr/dat/sel broadcast to both)
//   i_a_* / i_b_*         slave responses (ack, stall, err, read data)
module wbsplitter #(
  parameter int unsigned     DW        = 32,
  parameter int unsigned     AW        = 19,
  parameter logic [AW-1:0]   A_MASK    = 19'h40000,
  parameter logic [AW-1:0]   A_BASE    = 19'h00000,
  parameter logic [AW-1:0]   B_MASK    = 19'h60000,
  parameter logic [AW-1:0]   B_BASE    = 19'h40000,
  parameter int unsigned     LGMAXPEND = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cyc,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_adr,
  input  logic [DW-1:0]   i_dat,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_ack,
  output logic            o_stall,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  output logic            o_a_cyc,
  output logic            o_a_stb,
  output logic            o_a_we,
  output logic [AW-1:0]   o_a_adr,
  output logic [DW-1:0]   o_a_dat,
  output logic [DW/8-1:0] o_a_sel,
  input  logic            i_a_ack,
  input  logic            i_a_stall,
  input  logic            i_a_err,
  input  logic [DW-1:0]   i_a_data,
  output logic            o_b_cyc,
  output logic            o_b_stb,
  output logic            o_b_we,
  output logic [AW-1:0]   o_b_adr,
  output logic [DW-1:0]   o_b_dat,
  output logic [DW/8-1:0] o_b_sel,
  input  logic            i_b_ack,
  input  logic            i_b_stall,
  input  logic            i_b_err,
  input  logic [DW-1:0]   i_b_data
);

  typedef enum logic [1:0] {OwnNone = 2'd0, OwnA = 2'd1, OwnB = 2'd2} owner_e;

  localparam logic [LGMAXPEND-1:0] PendOne = LGMAXPEND'(1);

  owner_e               owner_q, owner_d, target;
  logic [LGMAXPEND-1:0] npend_q, npend_d;
  logic                 err_q, err_d;
  logic                 sel_a, sel_b, blocked, req;
  logic                 acc_a, acc_b, acc_err, own_ack, own_err;

  // Request fields go to both slaves unmuxed; only the strobes are steered.
  assign o_a_we  = i_we;
  assign o_a_adr = i_adr;
  assign o_a_dat = i_dat;
  assign o_a_sel = i_sel;
  assign o_b_we  = i_we;
  assign o_b_adr = i_adr;
  assign o_b_dat = i_dat;
  assign o_b_sel = i_sel;

  always_comb begin
    sel_a  = ((i_adr & A_MASK) == A_BASE);
    sel_b  = !sel_a && ((i_adr & B_MASK) == B_BASE);
    target = OwnNone;
    if (sel_a)      target = OwnA;
    else if (sel_b) target = OwnB;

    // A request may only join the burst already in flight; a full counter or a pending
    // decode error also holds the master off.
    blocked = ((npend_q != '0) && (target != owner_q)) || (&npend_q) || err_q;
    req     = !i_rst && i_cyc && i_stb && !blocked;

    o_a_stb = req && sel_a;
    o_b_stb = req && sel_b;
    acc_a   = o_a_stb && !i_a_stall;
    acc_b   = o_b_stb && !i_b_stall;
    acc_err = req && !sel_a && !sel_b;
    o_stall = i_rst || blocked || (sel_a && i_a_stall) || (sel_b && i_b_stall);

    own_ack = 1'b0;
    own_err = 1'b0;
    o_data  = i_a_data;
    unique case (owner_q)
      OwnA: begin
        own_ack = i_a_ack;
        own_err = i_a_err;
      end
      OwnB: begin
        own_ack = i_b_ack;
        own_err = i_b_err;
        o_data  = i_b_data;
      end
      default: ;
    endcase

    o_ack   = !i_rst && i_cyc && own_ack;
    o_err   = !i_rst && (err_q || (i_cyc && own_err));
    o_a_cyc = !i_rst && i_cyc && ((owner_q == OwnA) || o_a_stb);
    o_b_cyc = !i_rst && i_cyc && ((owner_q == OwnB) || o_b_stb);
  end

  always_comb begin
    npend_d = npend_q;
    owner_d = owner_q;
    err_d   = 1'b0;
    if (i_rst || !i_cyc) begin
      // Abort: anything still in flight is forgotten, late acks fall on owner NONE.
      npend_d = '0;
      owner_d = OwnNone;
    end else if (own_err) begin
      npend_d = '0;
      owner_d = OwnNone;
    end else begin
      err_d = acc_err;
      if ((acc_a || acc_b) && !own_ack) begin
        npend_d = npend_q + PendOne;
      end else if (!(acc_a || acc_b) && own_ack) begin
        npend_d = npend_q - PendOne;
      end
      if (acc_a)               owner_d = OwnA;
      else if (acc_b)          owner_d = OwnB;
      else if (npend_d == '0)  owner_d = OwnNone;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q <= OwnNone;
      npend_q <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      npend_q <= npend_d;
      err_q   <= err_d;
    end
  end

endmodule
